sparc_exu_ecc_sched: RTL and testbench

Shares the single two-stage EXU ECC generator (64-bit data in, 8-bit check bits out, one flop stage inside) among NREQ requesters, e.g. ALU writeback, load return, ASI write and scrub.
- Arbitrates round-robin and drives the generator's data and mask inputs.
- Carries data, requester id and tag alongside the generator pipeline.
- Buffers results in a 2-entry output FIFO with ready/valid backpressure.
- Owns the check-bit error-injection mask register (persistent or one-shot).

---
 rtl/sparc_exu_ecc_sched_pkg.sv | 20 ++
 rtl/sparc_exu_ecc_sched_if.sv | 32 +++
 rtl/sparc_exu_ecc_sched_fifo.sv | 43 ++++
 rtl/sparc_exu_ecc_sched.sv | 118 +++++++++++
 tb/tb_sparc_exu_ecc_sched.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sparc_exu_ecc_sched_pkg.sv
// Shared constants and the result-entry type for the EXU ECC generator scheduler.
package sparc_exu_ecc_sched_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 64;
  localparam int DEF_PW   = 8;
  localparam int DEF_TAGW = 5;
  localparam int DEF_IDW  = 2;

  localparam int FIFO_DEPTH = 2;
  localparam int CNTW       = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [DEF_IDW-1:0]  id;
    logic [DEF_TAGW-1:0] tag;
    logic [DEF_DW-1:0]   data;
    logic [DEF_PW-1:0]   ecc;
  } result_t;

endpackage

// File: rtl/sparc_exu_ecc_sched_if.sv
// Request and result channels of the ECC scheduler; master is the requester/consumer side.
interface sparc_exu_ecc_sched_if #(
  parameter int NREQ = sparc_exu_ecc_sched_pkg::DEF_NREQ,
  parameter int DW   = sparc_exu_ecc_sched_pkg::DEF_DW,
  parameter int PW   = sparc_exu_ecc_sched_pkg::DEF_PW,
  parameter int TAGW = sparc_exu_ecc_sched_pkg::DEF_TAGW,
  parameter int IDW  = sparc_exu_ecc_sched_pkg::DEF_IDW
);

  logic [NREQ-1:0]      req_vld;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_gnt;

  logic                 out_vld;
  logic                 out_rdy;
  logic [IDW-1:0]       out_id;
  logic [TAGW-1:0]      out_tag;
  logic [DW-1:0]        out_data;
  logic [PW-1:0]        out_ecc;

  modport master (
    output req_vld, req_data, req_tag, out_rdy,
    input  req_gnt, out_vld, out_id, out_tag, out_data, out_ecc
  );

  modport slave (
    input  req_vld, req_data, req_tag, out_rdy,
    output req_gnt, out_vld, out_id, out_tag, out_data, out_ecc
  );

endinterface

// File: rtl/sparc_exu_ecc_sched_fifo.sv
// Two-entry in-order result FIFO; simultaneous push and pop are legal even when full.
module sparc_exu_ecc_sched_fifo
  import sparc_exu_ecc_sched_pkg::*;
(
  input  logic            clk,
  input  logic            arst_l,
  input  logic            push,
  input  result_t         push_data,
  input  logic            pop,
  output result_t         head,
  output logic [CNTW-1:0] cnt
);

  localparam int PTRW = $clog2(FIFO_DEPTH);

  result_t         mem [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;

  // Entries are cleared on reset so an empty FIFO presents an all-zero head.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      cnt <= cnt + CNTW'(push) - CNTW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sparc_exu_ecc_sched.sv
// Round-robin sharing of the two-stage EXU ECC generator with error injection
// and a credit-controlled 2-entry result FIFO.
module sparc_exu_ecc_sched
  import sparc_exu_ecc_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int PW   = DEF_PW,
  parameter int TAGW = DEF_TAGW,
  parameter int IDW  = DEF_IDW
) (
  input  logic                  clk,
  input  logic                  arst_l,
  sparc_exu_ecc_sched_if.slave  bus,
  input  logic                  inj_wr,
  input  logic [PW-1:0]         inj_msk,
  input  logic                  inj_oneshot,
  output logic [DW-1:0]         gen_d,
  output logic [PW-1:0]         gen_msk,
  input  logic [PW-1:0]         gen_p,
  output logic                  busy
);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  sel_id;
  logic            found;
  logic            issue;
  logic            pop;
  logic [CNTW-1:0] fifo_cnt;
  logic [CNTW:0]   occupancy;

  logic            inflight;
  logic [IDW-1:0]  st_id;
  logic [TAGW-1:0] st_tag;
  logic [DW-1:0]   st_data;

  logic [PW-1:0]   inj_mask;
  logic            inj_mode_oneshot;
  logic            oneshot_armed;

  result_t         push_entry;
  result_t         head;

  assign pop = bus.out_vld & bus.out_rdy;

  // Slots still claimed after this cycle's pop; a new issue needs one free slot.
  assign occupancy = {1'b0, fifo_cnt} + (CNTW+1)'(inflight) - (CNTW+1)'(pop);

  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_vld[rr_ptr + IDW'(k)]) begin
        found  = 1'b1;
        sel_id = rr_ptr + IDW'(k);
      end
    end
  end

  // Gating with arst_l keeps the grant low for the whole reset window.
  assign issue       = arst_l & found & (occupancy < (CNTW+1)'(FIFO_DEPTH));
  assign bus.req_gnt = issue ? (NREQ'(1) << sel_id) : '0;
  assign gen_d       = issue ? bus.req_data[sel_id*DW +: DW] : '0;
  assign gen_msk     = (issue & (~inj_mode_oneshot | oneshot_armed)) ? inj_mask : '0;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rr_ptr   <= '0;
      inflight <= 1'b0;
      st_id    <= '0;
      st_tag   <= '0;
      st_data  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rr_ptr  <= sel_id + IDW'(1);
        st_id   <= sel_id;
        st_tag  <= bus.req_tag[sel_id*TAGW +: TAGW];
        st_data <= gen_d;
      end
    end
  end

  // A write in the issue cycle wins over the one-shot clear, so a fresh one-shot stays armed.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      inj_mask         <= '0;
      inj_mode_oneshot <= 1'b0;
      oneshot_armed    <= 1'b0;
    end else if (inj_wr) begin
      inj_mask         <= inj_msk;
      inj_mode_oneshot <= inj_oneshot;
      oneshot_armed    <= inj_oneshot;
    end else if (issue & oneshot_armed) begin
      oneshot_armed    <= 1'b0;
    end
  end

  assign push_entry = '{id: st_id, tag: st_tag, data: st_data, ecc: gen_p};

  sparc_exu_ecc_sched_fifo u_fifo (
    .clk       (clk),
    .arst_l    (arst_l),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign bus.out_vld  = (fifo_cnt != '0);
  assign bus.out_id   = head.id;
  assign bus.out_tag  = head.tag;
  assign bus.out_data = head.data;
  assign bus.out_ecc  = head.ecc;
  assign busy         = inflight | (fifo_cnt != '0);

endmodule

// File: tb/tb_sparc_exu_ecc_sched.sv
// Scoreboard bench for sparc_exu_ecc_sched with a behavioural one-flop ECC generator.
module tb_sparc_exu_ecc_sched;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int PW   = 8;
  localparam int TAGW = 5;

  typedef struct {
    int           id;
    int           tag;
    logic [63:0]  data;
    logic [7:0]   ecc;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_l;
  logic          inj_wr;
  logic [PW-1:0] inj_msk;
  logic          inj_oneshot;
  logic [DW-1:0] gen_d;
  logic [PW-1:0] gen_msk;
  logic [PW-1:0] gen_p = '0;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];
  int   gnt_log[$];
  int   id_log[$];
  int   tag_log[$];
  int   ecc_log[$];

  int          m_ptr;
  int          m_cnt;
  int          m_inflight;
  logic [7:0]  m_mask;
  bit          m_oneshot;
  bit          m_armed;

  int rr_exp[5]  = '{1, 2, 4, 8, 1};
  int rr_ids[5]  = '{0, 1, 2, 3, 0};
  int coinc[3]   = '{8'h80, 8'h02, 8'h00};

  sparc_exu_ecc_sched_if bus ();

  sparc_exu_ecc_sched dut (
    .clk         (clk),
    .arst_l      (arst_l),
    .bus         (bus.slave),
    .inj_wr      (inj_wr),
    .inj_msk     (inj_msk),
    .inj_oneshot (inj_oneshot),
    .gen_d       (gen_d),
    .gen_msk     (gen_msk),
    .gen_p       (gen_p),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ecc_fn(input logic [63:0] d);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      p[(i * 3 + i / 8) % 8] ^= d[i];
    end
    return p;
  endfunction

  // Generator: check bits of last cycle's data, flipped by last cycle's mask.
  always @(posedge clk) gen_p <= ecc_fn(gen_d) ^ gen_msk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model sampled mid-cycle: grant, credit, injection and ordering.
  always @(negedge clk) begin
    bit   pop;
    bit   found;
    int   occ;
    int   gidx;
    exp_t e;
    if (!arst_l) begin
      sb.delete();
      m_ptr = 0; m_cnt = 0; m_inflight = 0;
      m_mask = 8'h00; m_oneshot = 0; m_armed = 0;
    end else begin
      pop   = (m_cnt != 0) && (bus.out_rdy === 1'b1);
      occ   = m_cnt + m_inflight - (pop ? 1 : 0);
      found = 0;
      gidx  = 0;
      if (occ < 2) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!found && bus.req_vld[(m_ptr + k) % NREQ]) begin
            found = 1;
            gidx  = (m_ptr + k) % NREQ;
          end
        end
      end
      checkOutput("req_gnt", 64'(bus.req_gnt), found ? 64'(1 << gidx) : 64'd0);
      checkOutput("out_vld", 64'(bus.out_vld), 64'(m_cnt != 0));
      checkOutput("busy", 64'(busy), 64'(m_inflight != 0 || m_cnt != 0));
      if (pop && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("out_id", 64'(bus.out_id), 64'(e.id));
        checkOutput("out_tag", 64'(bus.out_tag), 64'(e.tag));
        checkOutput("out_data", bus.out_data, e.data);
        checkOutput("out_ecc", 64'(bus.out_ecc), 64'(e.ecc));
        id_log.push_back(int'(bus.out_id));
        tag_log.push_back(int'(bus.out_tag));
        ecc_log.push_back(int'(bus.out_ecc));
      end
      if (bus.req_gnt != '0) gnt_log.push_back(int'(bus.req_gnt));
      if (found) begin
        e.id   = gidx;
        e.tag  = int'(bus.req_tag[gidx*TAGW +: TAGW]);
        e.data = bus.req_data[gidx*DW +: DW];
        e.ecc  = ecc_fn(e.data) ^ ((!m_oneshot || m_armed) ? m_mask : 8'h00);
        sb.push_back(e);
        m_ptr = (gidx + 1) % NREQ;
      end
      if (inj_wr) begin
        m_mask = inj_msk; m_oneshot = inj_oneshot; m_armed = inj_oneshot;
      end else if (found && m_armed) begin
        m_armed = 0;
      end
      m_cnt      = m_cnt + m_inflight - (pop ? 1 : 0);
      m_inflight = found ? 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [63:0] data, input int tag);
    bit granted;
    granted = 0;
    bus.req_vld[id] = 1'b1;
    bus.req_data[id*DW +: DW] = data;
    bus.req_tag[id*TAGW +: TAGW] = TAGW'(tag);
    for (int c = 0; c < 50 && !granted; c++) begin
      @(negedge clk);
      if (bus.req_gnt[id]) granted = 1;
      else tick();
    end
    checkOutput("grant_seen", 64'(granted), 64'd1);
    tick();
    bus.req_vld[id] = 1'b0;
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
    tick();
  endtask

  task automatic clearLogs();
    gnt_log.delete(); id_log.delete(); tag_log.delete(); ecc_log.delete();
  endtask

  task automatic injWrite(input logic [7:0] msk, input logic oneshot);
    inj_wr = 1'b1; inj_msk = msk; inj_oneshot = oneshot;
    tick();
    inj_wr = 1'b0;
  endtask

  initial begin
    arst_l = 1'b0;
    inj_wr = 1'b0; inj_msk = '0; inj_oneshot = 1'b0;
    bus.req_vld = '0; bus.req_data = '0; bus.req_tag = '0; bus.out_rdy = 1'b1;

    #12;
    checkOutput("rst_gnt", 64'(bus.req_gnt), 64'd0);
    checkOutput("rst_gen_d", gen_d, 64'd0);
    checkOutput("rst_gen_msk", 64'(gen_msk), 64'd0);
    checkOutput("rst_out_vld", 64'(bus.out_vld), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_out_fields", 64'({bus.out_id, bus.out_tag, bus.out_ecc}) | bus.out_data, 64'd0);
    tick();
    arst_l = 1'b1;

    $display("[TB] round-robin");
    clearLogs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*DW +: DW] = {$urandom(), $urandom()};
      bus.req_tag[i*TAGW +: TAGW] = TAGW'(i + 8);
    end
    bus.req_vld = 4'hF;
    repeat (5) tick();
    bus.req_vld = '0;
    waitDrain();
    checkOutput("rr_count", 64'(gnt_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("rr_gnt%0d", i), 64'(gnt_log[i]), 64'(rr_exp[i]));
      checkOutput($sformatf("rr_id%0d", i), 64'(id_log[i]), 64'(rr_ids[i]));
    end

    $display("[TB] single op");
    clearLogs();
    applyStimulus(0, 64'd0, 3);
    waitDrain();
    checkOutput("single_count", 64'(id_log.size()), 64'd1);
    checkOutput("single_id", 64'(id_log[0]), 64'd0);
    checkOutput("single_ecc", 64'(ecc_log[0]), 64'h00);

    $display("[TB] one-shot injection");
    clearLogs();
    injWrite(8'h01, 1'b1);
    applyStimulus(2, 64'd0, 4);
    applyStimulus(2, 64'd0, 5);
    applyStimulus(1, 64'hDEAD_BEEF_0123_4567, 6);
    waitDrain();
    checkOutput("os_ecc0", 64'(ecc_log[0]), 64'h01);
    checkOutput("os_ecc1", 64'(ecc_log[1]), 64'h00);
    checkOutput("os_id0", 64'(id_log[0]), 64'd2);
    checkOutput("os_id1", 64'(id_log[1]), 64'd2);

    $display("[TB] backpressure");
    clearLogs();
    bus.out_rdy = 1'b0;
    applyStimulus(1, 64'h1111_0000_AAAA_0001, 1);
    applyStimulus(1, 64'h2222_0000_BBBB_0002, 2);
    bus.req_vld[1] = 1'b1;
    bus.req_tag[1*TAGW +: TAGW] = TAGW'(3);
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_gnt", 64'(bus.req_gnt), 64'd0);
      checkOutput("bp_tag", 64'(bus.out_tag), 64'd1);
    end
    tick();
    bus.out_rdy = 1'b1;
    applyStimulus(1, 64'h3333_0000_CCCC_0003, 3);
    waitDrain();
    checkOutput("bp_count", 64'(tag_log.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_order%0d", i), 64'(tag_log[i]), 64'(i + 1));
    end

    $display("[TB] coincident injection write");
    clearLogs();
    injWrite(8'h80, 1'b0);
    inj_wr = 1'b1; inj_msk = 8'h02; inj_oneshot = 1'b1;
    bus.req_vld[3] = 1'b1;
    bus.req_data[3*DW +: DW] = '0;
    bus.req_tag[3*TAGW +: TAGW] = TAGW'(6);
    @(negedge clk);
    checkOutput("coinc_gnt", 64'(bus.req_gnt), 64'd8);
    tick();
    inj_wr = 1'b0;
    bus.req_vld[3] = 1'b0;
    applyStimulus(3, 64'd0, 7);
    applyStimulus(3, 64'd0, 8);
    waitDrain();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("coinc_ecc%0d", i), 64'(ecc_log[i]), 64'(coinc[i]));
    end
    injWrite(8'h00, 1'b0);

    $display("[TB] reset mid-flight");
    clearLogs();
    bus.out_rdy = 1'b0;
    bus.req_vld = 4'hF;
    repeat (3) tick();
    #1;
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    checkOutput("pre_rst_vld", 64'(bus.out_vld), 64'd1);
    arst_l = 1'b0;
    #1;
    checkOutput("mid_rst_vld", 64'(bus.out_vld), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_gnt", 64'(bus.req_gnt), 64'd0);
    @(negedge clk);
    tick();
    arst_l = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_gnt", 64'(bus.req_gnt), 64'd1);
    tick();
    bus.req_vld = '0;
    bus.out_rdy = 1'b1;
    waitDrain();
    checkOutput("post_rst_id", 64'(id_log[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
